// File: rtl/pulse_duration_tx.sv
// Transmit side of the pulse-duration temperature link.
// Each accepted request becomes one frame on signal_out: a low pulse of N cycles, then a forced high gap.
module pulse_duration_tx #(
    parameter int MIN_T      = -40,
    parameter int MAX_T      = 125,
    parameter int MIN_RAW    = 1109,
    parameter int MAX_RAW    = 1601,
    parameter int SLOPE_Q8   = 763,
    parameter int GAP_CYCLES = 16,
    parameter int CNT_W      = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [8:0]       temp_in,
    input  logic [CNT_W-1:0] raw_in,
    output logic             signal_out,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] dur_out
);

    typedef enum logic [1:0] {IDLE, LOAD, LOW, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W-1:0] gap_cnt;

    logic signed [8:0] temp_s;
    logic signed [8:0] t_clamped;
    logic [8:0]        d;
    logic [19:0]       prod;
    logic [31:0]       n_temp;
    logic [CNT_W-1:0]  n_calc;

    assign temp_s = temp_in;

    // Fixed-point conversion: truncating Q8.8 scale, then clamp to the longest legal pulse.
    always_comb begin
        t_clamped = temp_s;
        if (temp_s < MIN_T)
            t_clamped = 9'(MIN_T);
        else if (temp_s > MAX_T)
            t_clamped = 9'(MAX_T);
        d      = 9'(t_clamped - 9'(MIN_T));
        prod   = 20'(d) * 20'(SLOPE_Q8);
        n_temp = 32'(MIN_RAW) + 32'(prod >> 8);
        if (n_temp > 32'(MAX_RAW))
            n_temp = 32'(MAX_RAW);
        if (in_mode)
            n_calc = (raw_in == '0) ? CNT_W'(1) : raw_in;
        else
            n_calc = CNT_W'(n_temp);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            signal_out <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            dur_out    <= '0;
            low_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    signal_out <= 1'b1;
                    if (in_valid && in_ready) begin
                        state    <= LOAD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        dur_out  <= n_calc;
                        low_cnt  <= n_calc;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= LOW;
                    signal_out <= 1'b0;
                end
                LOW: begin
                    if (low_cnt <= CNT_W'(1)) begin
                        state      <= GAP;
                        signal_out <= 1'b1;
                        gap_cnt    <= CNT_W'(GAP_CYCLES);
                        frame_done <= (GAP_CYCLES == 1);
                    end else begin
                        low_cnt <= low_cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    // frame_done is registered, so it is raised one edge ahead to land on the last gap cycle.
                    if (gap_cnt <= CNT_W'(1)) begin
                        state      <= IDLE;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        gap_cnt    <= gap_cnt - CNT_W'(1);
                        frame_done <= (gap_cnt == CNT_W'(2));
                    end
                end
                default: begin
                    state      <= IDLE;
                    signal_out <= 1'b1;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_duration_tx.sv
// Self-checking bench for pulse_duration_tx: directed frames plus randomized requests
// compared against an arithmetic model of the temperature-to-duration rule.
module tb_pulse_duration_tx;

    localparam int GAP = 16;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [8:0]  temp_in;
    logic [11:0] raw_in;
    logic        signal_out;
    logic        busy;
    logic        frame_done;
    logic [11:0] dur_out;

    int checks   = 0;
    int failures = 0;

    pulse_duration_tx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .temp_in    (temp_in),
        .raw_in     (raw_in),
        .signal_out (signal_out),
        .busy       (busy),
        .frame_done (frame_done),
        .dur_out    (dur_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: clamp, offset, scale by 2.982 (763/256) with truncation, clamp to 1601.
    function automatic int model_n(input bit mode, input int temp, input int raw);
        int t;
        int n;
        if (mode) return (raw == 0) ? 1 : raw;
        t = temp;
        if (t < -40) t = -40;
        if (t > 125) t = 125;
        n = 1109 + ((t + 40) * 763) / 256;
        if (n > 1601) n = 1601;
        return n;
    endfunction

    task automatic wait_ready(input string tag);
        int w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("%s_ready", tag), in_ready, 1);
    endtask

    // Present one request, then measure the whole frame on the line.
    task automatic send_frame(input bit mode, input int temp, input int raw, input int exp, input string tag);
        int low_len;
        int gap_len;
        int fd_cnt;
        int fd_pos;
        int gap_low;
        int overlap;
        @(negedge clk);
        in_mode  = mode;
        temp_in  = 9'(temp);
        raw_in   = 12'(raw);
        in_valid = 1'b1;
        wait_ready(tag);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        temp_in  = 9'($urandom);
        raw_in   = 12'($urandom);
        in_mode  = 1'($urandom);
        check($sformatf("%s_dur", tag), dur_out, exp);
        check($sformatf("%s_load_busy", tag), busy, 1);
        check($sformatf("%s_load_line", tag), signal_out, 1);
        check($sformatf("%s_load_ready", tag), in_ready, 0);
        @(posedge clk);
        #1;
        low_len = 0;
        while (signal_out === 1'b0 && low_len < 5000) begin
            low_len++;
            @(posedge clk);
            #1;
        end
        gap_len = 0; fd_cnt = 0; fd_pos = -1; gap_low = 0; overlap = 0;
        while (in_ready !== 1'b1 && gap_len < 100) begin
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_pos = gap_len;
            end
            if (signal_out !== 1'b1) gap_low++;
            gap_len++;
            @(posedge clk);
            #1;
        end
        if (frame_done === 1'b1 && in_ready === 1'b1) overlap = 1;
        check($sformatf("%s_low_len", tag), low_len, exp);
        check($sformatf("%s_gap_len", tag), gap_len, GAP);
        check($sformatf("%s_gap_low", tag), gap_low, 0);
        check($sformatf("%s_done_cnt", tag), fd_cnt, 1);
        check($sformatf("%s_done_pos", tag), fd_pos, GAP - 1);
        check($sformatf("%s_done_ready_overlap", tag), overlap, 0);
        check($sformatf("%s_idle_busy", tag), busy, 0);
        $display("frame %s mode=%0d low=%0d gap=%0d dur=%0d exp=%0d", tag, mode, low_len, gap_len, dur_out, exp);
    endtask

    initial begin
        int line_q[$];
        int runs[$];
        int fd_total;
        int pending;
        int fd_seen;
        int ti;
        int ri;
        int run_val;
        int run_len;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        temp_in  = '0;
        raw_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_line", signal_out, 1);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_dur", dur_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("rel_ready", in_ready, 1);
        check("rel_line", signal_out, 1);
        check("rel_busy", busy, 0);
        check("rel_dur", dur_out, 0);
        $display("reset release ready=%0d line=%0d", in_ready, signal_out);

        send_frame(0, 25, 0, 1302, "t25");
        send_frame(0, -100, 0, 1109, "tm100");
        send_frame(0, -40, 0, 1109, "tm40");
        send_frame(0, 0, 0, 1228, "t0");
        send_frame(0, 125, 0, 1600, "t125");
        send_frame(0, 200, 0, 1600, "t200");
        send_frame(0, 85, 0, 1481, "t85");
        send_frame(1, 0, 0, 1, "raw0");
        send_frame(1, 0, 4095, 4095, "raw4095");

        // Back-to-back raw 5 then 7 with in_valid held; later input changes must not matter.
        @(negedge clk);
        in_mode  = 1'b1;
        raw_in   = 12'd5;
        in_valid = 1'b1;
        wait_ready("b2b");
        @(posedge clk);
        #1;
        raw_in = 12'd7;
        pending = 0;
        fd_total = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (pending != 0) begin
                raw_in   = 12'd100;
                in_mode  = 1'b0;
                in_valid = 1'b0;
                pending  = 0;
            end
            if (in_ready === 1'b1 && in_valid === 1'b1) pending = 1;
            if (frame_done === 1'b1) fd_total++;
            line_q.push_back(int'(signal_out));
        end
        run_val = line_q[0];
        run_len = 0;
        foreach (line_q[i]) begin
            if (line_q[i] == run_val) run_len++;
            else begin
                runs.push_back(run_len);
                run_val = line_q[i];
                run_len = 1;
            end
        end
        runs.push_back(run_len);
        check("b2b_first_is_low", line_q[0], 0);
        check("b2b_run_count", runs.size(), 4);
        if (runs.size() >= 3) begin
            check("b2b_low1", runs[0], 5);
            check("b2b_high_between", runs[1], GAP + 2);
            check("b2b_low2", runs[2], 7);
        end
        check("b2b_done_total", fd_total, 2);
        check("b2b_dur", dur_out, 7);
        $display("b2b runs=%0d low1=%0d high=%0d low2=%0d done=%0d", runs.size(),
                 runs.size() > 0 ? runs[0] : -1, runs.size() > 1 ? runs[1] : -1,
                 runs.size() > 2 ? runs[2] : -1, fd_total);

        // Reset 100 cycles into LOW.
        @(negedge clk);
        in_mode  = 1'b0;
        temp_in  = 9'd25;
        in_valid = 1'b1;
        wait_ready("abort");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (101) @(posedge clk);
        #1;
        check("abort_line_low", signal_out, 0);
        reset_n = 1'b0;
        #1;
        check("abort_line_async", signal_out, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 0);
        fd_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) fd_seen++;
        end
        check("abort_no_done", fd_seen, 0);
        $display("abort line=%0d busy=%0d done_seen=%0d", signal_out, busy, fd_seen);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(0, 25, 0, 1302, "after_abort");

        for (int r = 0; r < 8; r++) begin
            if (($urandom & 1) != 0) begin
                ri = int'($urandom_range(0, 300));
                send_frame(1, 0, ri, model_n(1, 0, ri), $sformatf("rnd_raw%0d", r));
            end else begin
                ti = int'($urandom_range(0, 511)) - 256;
                send_frame(0, ti, 0, model_n(0, ti, 0), $sformatf("rnd_t%0d", r));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_duration_tx.md
Name: pulse_duration_tx

Overview:
- Transmit end of the single-wire pulse-duration temperature link.
- Accepts a signed temperature or a raw count through a valid/ready handshake.
- Converts the temperature to a low-pulse length with fixed-point arithmetic and drives one frame on signal_out: idle high, low for exactly N clock cycles, then a guaranteed high gap.
- Used as the sensor-side model and as loopback stimulus for the receiver.

Parameters:
- MIN_T, -40, lowest encodable temperature (°C).
- MAX_T, 125, highest encodable temperature (°C).
- MIN_RAW, 1109, pulse length in cycles at MIN_T.
- MAX_RAW, 1601, upper clamp for pulse length.
- SLOPE_Q8, 763, cycles per °C in unsigned Q8.8 (2.982 × 256).
- GAP_CYCLES, 16, high cycles forced after every low pulse (≥1).
- CNT_W, 12, width of duration and counters.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_mode  in  1  0 = temperature from temp_in, 1 = raw count from raw_in.
- temp_in  in  9  signed two's-complement temperature, °C.
- raw_in  in  CNT_W  raw low-pulse length in cycles.
- signal_out  out  1  encoded line; idle high.
- busy  out  1  high while a frame (LOAD/LOW/GAP) is in progress.
- frame_done  out  1  one-cycle pulse when GAP completes.
- dur_out  out  CNT_W  duration N of the most recently accepted frame.

Behaviour:
- Reset (asynchronous, on reset_n low, immediate):
  - signal_out = 1, in_ready = 0, busy = 0, frame_done = 0, dur_out = 0.
  - state = IDLE, counters = 0.
  - in_ready rises the first clock edge after reset_n deasserts.
- States:
  - IDLE: signal_out = 1, in_ready = 1. Acceptance when in_valid && in_ready at a rising edge. Inputs are sampled only at acceptance; outside IDLE, in_valid is ignored and no request is queued.
  - LOAD (1 cycle, entered on the acceptance edge): in_ready = 0, busy = 1, signal_out = 1. The duration computed from the inputs sampled at acceptance is registered into dur_out and the down-counter.
  - LOW: entered at the LOAD→LOW edge. signal_out = 0 for exactly N consecutive cycles, then GAP.
  - GAP: signal_out = 1 for exactly GAP_CYCLES cycles. On the last GAP cycle frame_done = 1. Next state is IDLE, with in_ready = 1 from the following cycle.
- Latency and throughput:
  - Acceptance at edge k → signal_out falls after edge k+1 and rises after edge k+1+N.
  - in_ready returns after edge k+1+N+GAP_CYCLES.
  - Back-to-back frames are separated by at least GAP_CYCLES+2 high cycles.
- Temperature conversion (in_mode = 0):
  - t = clamp(temp_in, MIN_T, MAX_T).
  - d = t − MIN_T, unsigned, 0..165.
  - N = MIN_RAW + ((d × SLOPE_Q8) >> 8): truncating shift, ≥18-bit product, no rounding.
  - N is then clamped to MAX_RAW.
  - Examples: −40 → 1109; 25 → 1302; 125 → 1600; −100 → 1109; 200 → 1600.
- Raw mode (in_mode = 1):
  - N = raw_in, except raw_in = 0 gives N = 1 (a pulse is never empty).
  - No MAX_RAW clamp in raw mode; up to 2^CNT_W − 1.
- Counters: the LOW counter counts down from N to 1; the GAP counter counts down from GAP_CYCLES to 1. Neither wraps.
- frame_done and in_ready are never high in the same cycle.
- Reset mid-frame (any state): the line returns high immediately and the frame is abandoned. No frame_done is produced for the aborted frame.
- busy = 1 exactly in LOAD, LOW and GAP.

Test Plan:
- Reset release, in_valid = 0 → signal_out = 1, busy = 0, in_ready = 1 from the first edge after release, dur_out = 0.
- Temperature 25 accepted at edge k → dur_out = 1302; signal_out low for exactly 1302 cycles starting after edge k+1; high for 16 cycles; frame_done one pulse; in_ready returns after edge k+1319.
- Clamp and endpoint sweep: temp_in −100, −40, 0, 125, 200 → N = 1109, 1109, 1228, 1600, 1600 respectively, measured on the line.
- Raw mode: raw_in = 0 → 1-cycle low pulse; raw_in = 4095 → 4095-cycle low pulse; raw_in = 5 then 7 presented back-to-back with in_valid held high → two frames of 5 and 7 low cycles separated by exactly 18 high cycles; inputs changed during a frame have no effect.
- Reset asserted 100 cycles into LOW → signal_out high asynchronously (before the next edge), no frame_done; after release a new 25 °C request produces a correct 1302-cycle pulse.
- Loopback with the receiver (temperature −40, 25, 85) → the receiver reports pulse durations 1109, 1302, 1481, matching dur_out.
